motor_pwm_ctrl: RTL

- Sequences one motor PWM channel for the drive train from a single 50 MHz clock.
- Internally prescales the clock to a 3.125 MHz tick enable and runs an 8-bit PWM period counter, giving 4096 clk_50M cycles per period.
- Accepts speed/direction commands over a valid/ready handshake.
- Ramps duty toward the target at PWM-period boundaries and enforces a ramp-to-zero plus dead-time dwell before any direction reversal.

---
 rtl/motor_pwm_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/motor_pwm_ctrl.sv
// Single-channel motor PWM sequencer: prescaled 8-bit PWM, handshaked speed/direction commands,
// per-period duty ramping and a ramp-to-zero plus dead-time dwell before any direction reversal.
module motor_pwm_ctrl #(
  parameter int PRESCALE     = 16,
  parameter int STEP         = 8,
  parameter int DEAD_PERIODS = 2
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_duty,
  input  logic       cmd_dir,
  input  logic       estop,
  output logic       pwm_out,
  output logic       dir_out,
  output logic [7:0] cur_duty,
  output logic       busy
);

  localparam int PSW = $clog2(PRESCALE);
  localparam int DWW = $clog2(DEAD_PERIODS + 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
  localparam logic [DWW-1:0] DW_LAST = DWW'(DEAD_PERIODS - 1);
  localparam logic [7:0]     STEP8   = 8'(STEP);

  typedef enum logic [2:0] {IDLE, RAMP, HOLD, DECEL, DWELL} state_t;

  state_t         state, state_nx;
  logic [PSW-1:0] presc_cnt;
  logic [7:0]     pwm_cnt;
  logic [7:0]     target, target_nx, duty_nx;
  logic           tdir, tdir_nx, dir_nx;
  logic [DWW-1:0] dwell_cnt, dwell_nx;
  logic           tick, period_end, accept;
  logic [7:0]     ramp_duty, decel_duty;

  // One step toward tgt, clamped so it never overshoots (no wrap at 0 or 255).
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)
      return ((tgt - cur) <= STEP8) ? tgt : cur + STEP8;
    else
      return ((cur - tgt) <= STEP8) ? tgt : cur - STEP8;
  endfunction

  assign tick       = (presc_cnt == PS_LAST);
  assign period_end = tick && (pwm_cnt == 8'hFF);
  assign cmd_ready  = (state == IDLE || state == HOLD) && !estop && !rst;
  assign busy       = (state == RAMP) || (state == DECEL) || (state == DWELL);
  assign accept     = cmd_valid && cmd_ready;
  assign ramp_duty  = step_toward(cur_duty, target);
  assign decel_duty = step_toward(cur_duty, 8'd0);

  always_comb begin
    state_nx  = state;
    duty_nx   = cur_duty;
    target_nx = target;
    tdir_nx   = tdir;
    dir_nx    = dir_out;
    dwell_nx  = dwell_cnt;
    if (estop) begin
      state_nx  = IDLE;
      duty_nx   = 8'd0;
      target_nx = 8'd0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            target_nx = cmd_duty;
            tdir_nx   = cmd_dir;
            // A stopped motor may flip direction at once; a running one must decelerate first.
            if (cmd_dir == dir_out || cur_duty == 8'd0) begin
              dir_nx = cmd_dir;
              if (cmd_duty == cur_duty && cmd_dir == dir_out)
                state_nx = (cmd_duty == 8'd0) ? IDLE : HOLD;
              else
                state_nx = RAMP;
            end else begin
              state_nx = DECEL;
            end
          end
        end
        RAMP: begin
          if (period_end) begin
            duty_nx = ramp_duty;
            if (ramp_duty == target)
              state_nx = (target == 8'd0) ? IDLE : HOLD;
          end
        end
        DECEL: begin
          if (period_end) begin
            duty_nx = decel_duty;
            if (decel_duty == 8'd0) begin
              state_nx = DWELL;
              dir_nx   = tdir;
              dwell_nx = '0;
            end
          end
        end
        DWELL: begin
          if (period_end) begin
            if (dwell_cnt == DW_LAST)
              state_nx = (target == 8'd0) ? IDLE : RAMP;
            else
              dwell_nx = dwell_cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      presc_cnt <= '0;
      pwm_cnt   <= 8'd0;
      pwm_out   <= 1'b0;
      state     <= IDLE;
      cur_duty  <= 8'd0;
      target    <= 8'd0;
      tdir      <= 1'b0;
      dir_out   <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick)
        pwm_cnt <= pwm_cnt + 8'd1;
      pwm_out   <= (pwm_cnt < cur_duty);
      state     <= state_nx;
      cur_duty  <= duty_nx;
      target    <= target_nx;
      tdir      <= tdir_nx;
      dir_out   <= dir_nx;
      dwell_cnt <= dwell_nx;
    end
  end

endmodule
